// File: rtl/regfile_dec_32x64_if.sv
// Bus bundle for the 32x64 register file: one write port, two read ports and the
// decoded write-enable vector exported for observation.
interface regfile_dec_32x64_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [DATA_W-1:0]      wr_data;
    logic [ADDR_W-1:0]      rd_addr_a;
    logic [ADDR_W-1:0]      rd_addr_b;
    logic [DATA_W-1:0]      rd_data_a;
    logic [DATA_W-1:0]      rd_data_b;
    logic [2**ADDR_W-1:0]   wr_onehot;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, wr_onehot
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, wr_onehot
    );
endinterface

// File: rtl/regfile_dec_32x64.sv
// 32 x 64-bit register file: decoded write port, two combinational read ports, X31 reads zero.
// Optional write-through forwarding on the read ports when REGFILE_BYPASS_EN is defined.
module regfile_dec_32x64 #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    regfile_dec_32x64_if.slave bus
);
    localparam int NREG   = 2**ADDR_W;
    localparam int NSTORE = NREG - 1;                 // top index is the zero register
    localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(NSTORE);

    logic [NREG-1:0]   wr_onehot;
    logic [DATA_W-1:0] regs_q [NSTORE];
    logic [DATA_W-1:0] regs_d [NSTORE];
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_onehot = '0;
        for (int i = 0; i < NSTORE; i++) begin
            if (bus.wr_en && (bus.wr_addr == ADDR_W'(i))) wr_onehot[i] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NSTORE; i++) begin
            regs_d[i] = wr_onehot[i] ? bus.wr_data : regs_q[i];
        end
    end

    // NOTE: the array is cleared by the async reset because the register file contents
    // are architecturally visible after reset; a RAM macro would not allow this.
    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NSTORE; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < NSTORE; i++) regs_q[i] <= regs_d[i];
        end
    end

    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int i = 0; i < NSTORE; i++) begin
            if (bus.rd_addr_a == ADDR_W'(i)) rd_a = regs_q[i];
            if (bus.rd_addr_b == ADDR_W'(i)) rd_b = regs_q[i];
        end
`ifdef REGFILE_BYPASS_EN
        // Forward the pending write; suppressed while reset holds the array at zero.
        if (reset_n && bus.wr_en && (bus.wr_addr != ZERO_REG)) begin
            if (bus.rd_addr_a == bus.wr_addr) rd_a = bus.wr_data;
            if (bus.rd_addr_b == bus.wr_addr) rd_b = bus.wr_data;
        end
`endif
    end

    assign bus.rd_data_a = rd_a;
    assign bus.rd_data_b = rd_b;
    assign bus.wr_onehot = wr_onehot;
endmodule
